// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package fetch_pkg;

  localparam int XLEN   = 32;
  localparam int INST_W = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry circular buffer of fetch entries; flush wins over push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               wrEntry,
  output fetch_entry_t               rdEntry,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t       mem [DEPTH];
  logic [PTR_W-1:0]   wrPtr;
  logic [PTR_W-1:0]   rdPtr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage carries no reset; the top masks the head while the queue is empty.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wrPtr] <= wrEntry;
  end

  assign rdEntry = mem[rdPtr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch PC, single-outstanding imem request control and instruction queue.
// Optional combinational ack-to-decode bypass: FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_pc_plus4,
  input  logic        inst_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic              reqQ, reqD;
  logic              dropQ, dropD;
  logic [XLEN-1:0]   addrQ, addrD;
  logic [XLEN-1:0]   fetchPc, fetchPcD;
  logic [XLEN-1:0]   pcSel;
  logic [CNT_W-1:0]  count, nextCount;
  logic              ackValid, headValid, bypassHit, bypassTake;
  logic              fifoPush, fifoPop;
  fetch_entry_t      pushEntry, headEntry, outEntry;

  assign ackValid  = reqQ && imem_ack;
  assign headValid = (count != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypassHit  = !headValid && ackValid && !dropQ;
  assign bypassTake = bypassHit && inst_ready && !redirect;
`else
  assign bypassHit  = 1'b0;
  assign bypassTake = 1'b0;
`endif

  assign fifoPush  = ackValid && !dropQ && !redirect && !bypassTake;
  assign fifoPop   = headValid && inst_ready && !redirect;
  assign pushEntry = '{pc: addrQ, inst: imem_rdata};

  fetch_fifo #(.DEPTH(DEPTH)) uFifo (
    .clk     (clk),
    .rst     (reset),
    .push    (fifoPush),
    .pop     (fifoPop),
    .flush   (redirect),
    .wrEntry (pushEntry),
    .rdEntry (headEntry),
    .count   (count)
  );

  always_comb begin
    nextCount = redirect ? '0 : count + CNT_W'(fifoPush) - CNT_W'(fifoPop);
  end

  // Request control: hold an unacked request; otherwise issue if a slot will be free.
  always_comb begin
    reqD     = reqQ;
    addrD    = addrQ;
    fetchPcD = fetchPc;
    dropD    = dropQ;
    pcSel    = redirect ? alignPc(redirect_pc) : fetchPc;
    if (ackValid) dropD = 1'b0;
    if (reqQ && !imem_ack) begin
      if (redirect) begin
        dropD    = 1'b1;
        fetchPcD = pcSel;
      end
    end else begin
      reqD = (nextCount < DEPTH_C);
      if (reqD) begin
        addrD    = pcSel;
        fetchPcD = pcSel + PC_STEP;
      end else begin
        fetchPcD = pcSel;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reqQ    <= 1'b0;
      dropQ   <= 1'b0;
      addrQ   <= RESET_PC;
      fetchPc <= RESET_PC;
    end else begin
      reqQ    <= reqD;
      dropQ   <= dropD;
      addrQ   <= addrD;
      fetchPc <= fetchPcD;
    end
  end

  always_comb begin
    outEntry = '0;
    if (bypassHit)      outEntry = pushEntry;
    else if (headValid) outEntry = headEntry;
  end

  assign imem_req      = reqQ;
  assign imem_addr     = addrQ;
  assign inst_valid    = headValid || bypassHit;
  assign inst          = outEntry.inst;
  assign inst_pc       = outEntry.pc;
  assign inst_pc_plus4 = outEntry.pc + PC_STEP;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based transaction model.
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pc_plus4;
  logic        inst_ready = 1'b0;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_pc_plus4 (inst_pc_plus4),
    .inst_ready    (inst_ready)
  );

  always #5 clk = ~clk;

  int nChecks = 0;
  int nFail   = 0;

  // Reference model: pending request, drop flag, next fetch PC and a FIFO of {pc, inst}
  bit          mReq;
  bit          mDrop;
  logic [31:0] mAddr;
  logic [31:0] mPc;
  logic [63:0] mQ[$];

  // Memory responder and stimulus knobs
  bit          memBusy;
  int          waitCnt, curLat;
  int          latMode;
  int          readyMode;
  int          rdataMode;
  int          redirProb;
  bit          redirNow;
  logic [31:0] redirTarget;
  logic [31:0] addrLog[$];
  logic [31:0] pcLog[$];

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0013;
  endfunction

  task automatic modelReset();
    mReq = 0; mDrop = 0; mAddr = RESET_PC; mPc = RESET_PC;
    mQ.delete();
    memBusy = 0; waitCnt = 0; curLat = 0;
    addrLog.delete(); pcLog.delete();
  endtask

  task automatic doReset();
    reset = 1'b1; imem_ack = 1'b0; redirect = 1'b0; inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkEq("rst_req", imem_req, 0);
    checkEq("rst_addr", imem_addr, RESET_PC);
    checkEq("rst_valid", inst_valid, 0);
    checkEq("rst_inst", inst, 0);
    checkEq("rst_pc", inst_pc, 0);
    checkEq("rst_pc4", inst_pc_plus4, 4);
    reset = 1'b0;
    modelReset();
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, advance the model.
  task automatic step();
    bit          redir, ack, ready, acked, empty, bypass, expValid, popped;
    logic [31:0] rpc, rdata, target;
    logic [63:0] head;
    redir = redirNow || (redirProb != 0 && $urandom_range(redirProb - 1, 0) == 0);
    rpc   = redirNow ? redirTarget : ($urandom & 32'h0000_3FFF);
    redirNow = 0;
    if (imem_req && !memBusy) begin
      memBusy = 1; waitCnt = 0;
      curLat = (latMode < 0) ? int'($urandom_range(3, 0)) : latMode;
      addrLog.push_back(imem_addr);
    end
    ack   = imem_req && memBusy && (waitCnt == curLat);
    rdata = (rdataMode == 0) ? 32'h0000_0013 : memWord(imem_addr);
    case (readyMode)
      0:       ready = 0;
      1:       ready = 1;
      default: ready = ($urandom_range(3, 0) != 0);
    endcase
    imem_ack = ack; imem_rdata = rdata; inst_ready = ready;
    redirect = redir; redirect_pc = rpc;
    #1;
    empty  = (mQ.size() == 0);
    acked  = mReq && ack;
    bypass = 0;
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass = empty && acked && !mDrop;
`endif
    expValid = !empty || bypass;
    checkEq("req", imem_req, mReq);
    checkEq("addr", imem_addr, mAddr);
    checkEq("valid", inst_valid, expValid);
    checkEq("xfree", $isunknown({inst, inst_pc, inst_pc_plus4}), 0);
    if (expValid) begin
      head = bypass ? {mAddr, rdata} : mQ[0];
      checkEq("inst", inst, head[31:0]);
      checkEq("pc", inst_pc, head[63:32]);
      checkEq("pc4", inst_pc_plus4, head[63:32] + 32'd4);
    end
    popped = 0;
    if (expValid && ready && !redir) begin
      pcLog.push_back(inst_pc);
      if (!empty) void'(mQ.pop_front());
      else popped = 1;
    end
    if (acked && !mDrop && !redir && !popped) mQ.push_back({mAddr, rdata});
    if (redir) mQ.delete();
    target = redir ? {rpc[31:2], 2'b00} : mPc;
    if (mReq && !ack) begin
      if (redir) begin mDrop = 1; mPc = target; end
    end else begin
      if (acked) mDrop = 0;
      if (mQ.size() < DEPTH) begin
        mReq = 1; mAddr = target; mPc = target + 32'd4;
      end else begin
        mReq = 0; mPc = target;
      end
    end
    if (ack) memBusy = 0;
    else if (memBusy) waitCnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    bit found;
    latMode = 0; readyMode = 1; rdataMode = 0; redirProb = 0;
    redirNow = 0; redirTarget = '0;
    modelReset();

    // Zero-wait memory, constant NOP data: one request and one instruction per cycle
    doReset();
    repeat (8) step();
    checkEq("zw_rate", addrLog.size(), 7);
    for (int i = 0; i < 3; i++) begin
      if (addrLog.size() > i) checkEq("zw_addr", addrLog[i], 4 * i);
      if (pcLog.size() > i)   checkEq("zw_pc", pcLog[i], 4 * i);
    end

    // Decode stalled: queue fills, requests stop, then resume at 16
    rdataMode = 1;
    doReset();
    readyMode = 0;
    repeat (8) step();
    checkEq("full_pushes", addrLog.size(), 4);
    checkEq("full_req", imem_req, 0);
    checkEq("full_valid", inst_valid, 1);
    readyMode = 1;
    step();
    checkEq("rearm_req", imem_req, 1);
    checkEq("rearm_addr", imem_addr, 32'h10);

    // Slow memory: redirect while the request to 8 is outstanding drops its data
    doReset();
    latMode = 2; readyMode = 1; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (addrLog.size() > 0 && addrLog[$] == 32'h8) found = 1;
    end
    checkEq("wait_req8", found, 1);
    redirNow = 1; redirTarget = 32'h100;
    step();
    addrLog.delete(); pcLog.delete();
    repeat (20) step();
    checkEq("drop_n", addrLog.size() > 0 && pcLog.size() > 0, 1);
    if (addrLog.size() > 0) checkEq("drop_addr", addrLog[0], 32'h100);
    if (pcLog.size() > 0)   checkEq("drop_pc", pcLog[0], 32'h100);

    // Redirect with a simultaneous pop and three entries queued; unaligned target
    doReset();
    latMode = 0; readyMode = 0; found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (mQ.size() == 3) found = 1;
    end
    checkEq("wait_q3", found, 1);
    readyMode = 1; redirNow = 1; redirTarget = 32'h103;
    step();
    checkEq("redir_valid", inst_valid, 0);
    checkEq("redir_req", imem_req, 1);
    checkEq("redir_addr", imem_addr, 32'h100);
    pcLog.delete();
    repeat (10) step();
    if (pcLog.size() > 1) begin
      checkEq("redir_pc0", pcLog[0], 32'h100);
      checkEq("redir_pc1", pcLog[1], 32'h104);
    end else checkEq("redir_popn", pcLog.size(), 2);

    // Reset while a request is outstanding with two entries queued
    doReset();
    latMode = 3; readyMode = 0; found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (mQ.size() == 2 && memBusy) found = 1;
    end
    checkEq("wait_q2", found, 1);
    reset = 1'b1;
    #1;
    checkEq("mid_req", imem_req, 0);
    checkEq("mid_valid", inst_valid, 0);
    checkEq("mid_addr", imem_addr, RESET_PC);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    checkEq("mid_ackign", inst_valid, 0);
    imem_ack = 1'b0; reset = 1'b0;
    modelReset();
    latMode = 0; readyMode = 1;
    repeat (4) step();
    if (addrLog.size() > 0) checkEq("mid_first", addrLog[0], RESET_PC);
    else checkEq("mid_reqn", addrLog.size(), 1);

    // Random latency, backpressure and redirects
    latMode = -1; readyMode = 2; redirProb = 16;
    repeat (3000) step();
    redirProb = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
